// File: rtl/issue_ctrl_pkg.sv
// Shared instruction format, opcode map, FSM states and class decode for the
// in-order issue controller.
package issue_ctrl_pkg;

   localparam int INSTR_WIDTH    = 32;
   localparam int OPCODE_WIDTH   = 4;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2**REG_ADDR_WIDTH;

   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_NOP  = 4'd0,
      OP_LW   = 4'd1,
      OP_SW   = 4'd2,
      OP_ADD  = 4'd3,
      OP_SUB  = 4'd4,
      OP_MUL  = 4'd5,
      OP_DIV  = 4'd6,
      OP_AND  = 4'd7,
      OP_OR   = 4'd8,
      OP_NOT  = 4'd9,
      OP_CMP  = 4'd10,
      OP_JR   = 4'd11,
      OP_JPC  = 4'd12,
      OP_BRFL = 4'd13,
      OP_CALL = 4'd14,
      OP_RET  = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,
      ST_MD_BUSY = 2'd1,
      ST_BR_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic writes_r1;
      logic reads_r1;
      logic reads_r2;
      logic reads_flags;
      logic sets_flags;
      logic is_ctrl;
      logic is_mul;
      logic is_div;
   } iclass_t;

   function automatic iclass_t decode_class(input opcode_e op);
      iclass_t c;
      c = '0;
      case (op)
         OP_LW:   begin c.writes_r1 = 1'b1; c.reads_r2 = 1'b1; end
         OP_SW:   begin c.reads_r1 = 1'b1; c.reads_r2 = 1'b1; end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            c.writes_r1 = 1'b1; c.reads_r1 = 1'b1; c.reads_r2 = 1'b1;
         end
         OP_MUL:  begin c.writes_r1 = 1'b1; c.reads_r1 = 1'b1; c.reads_r2 = 1'b1; c.is_mul = 1'b1; end
         OP_DIV:  begin c.writes_r1 = 1'b1; c.reads_r1 = 1'b1; c.reads_r2 = 1'b1; c.is_div = 1'b1; end
         OP_NOT:  begin c.writes_r1 = 1'b1; c.reads_r2 = 1'b1; end
         OP_CMP:  begin c.reads_r1 = 1'b1; c.reads_r2 = 1'b1; c.sets_flags = 1'b1; end
         OP_JR:   begin c.reads_r1 = 1'b1; c.is_ctrl = 1'b1; end
         OP_BRFL: begin c.reads_flags = 1'b1; c.is_ctrl = 1'b1; end
         OP_JPC, OP_CALL, OP_RET: c.is_ctrl = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register and flags pending-write scoreboard; a set and a clear of the same
// entry in one cycle leaves the entry set.
module issue_ctrl_scoreboard
   import issue_ctrl_pkg::*;
(
   input  logic                      clk_in,
   input  logic                      RST,
   input  logic                      set_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
   input  logic                      clr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
   input  logic                      flag_set_i,
   input  logic                      flag_clr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd2_addr_i,
   output logic                      rd1_pend_o,
   output logic                      rd2_pend_o,
   output logic                      flag_pend_o
);

   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic                flag_q, flag_d;

   always_comb begin
      pend_d = pend_q;
      flag_d = flag_q;
      if (clr_en_i)   pend_d[clr_addr_i] = 1'b0;
      if (set_en_i)   pend_d[set_addr_i] = 1'b1;
      if (flag_clr_i) flag_d = 1'b0;
      if (flag_set_i) flag_d = 1'b1;
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         pend_q <= '0;
         flag_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         flag_q <= flag_d;
      end
   end

   // rd1 doubles as the WAW check since the destination is always R1
   assign rd1_pend_o  = pend_q[rd1_addr_i];
   assign rd2_pend_o  = pend_q[rd2_addr_i];
   assign flag_pend_o = flag_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller in front of the decode/register-read stage:
// hazard stalls, MUL/DIV occupancy, control-transfer wait and stall counting.
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      clk_in,
   input  logic                      RST,
   input  logic [INSTR_WIDTH-1:0]    in_instr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      wb_en,
   input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
   input  logic                      wb_flag_en,
   input  logic                      br_done,
   output logic [INSTR_WIDTH-1:0]    out_instr,
   output logic                      out_valid,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int BUSY_W     = $clog2(MAX_CYCLES + 1);
   localparam logic [BUSY_W-1:0] MUL_LOAD = BUSY_W'(MUL_CYCLES - 1);
   localparam logic [BUSY_W-1:0] DIV_LOAD = BUSY_W'(DIV_CYCLES - 1);

   state_e                   state_q, state_d;
   logic [BUSY_W-1:0]        busy_q, busy_d;
   logic [INSTR_WIDTH-1:0]   out_instr_q, out_instr_d;
   logic                     out_valid_q, out_valid_d;
   logic [CNT_WIDTH-1:0]     stall_q, stall_d;

   opcode_e                  op;
   iclass_t                  cls;
   logic [REG_ADDR_WIDTH-1:0] r1, r2;
   logic                     r1_pend, r2_pend, flag_pend;
   logic                     hazard, accept;

   assign op  = opcode_e'(in_instr[OPCODE_WIDTH-1:0]);
   assign r1  = in_instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
   assign r2  = in_instr[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
   assign cls = decode_class(op);

   issue_ctrl_scoreboard u_sb (
      .clk_in      (clk_in),
      .RST         (RST),
      .set_en_i    (accept && cls.writes_r1),
      .set_addr_i  (r1),
      .clr_en_i    (wb_en),
      .clr_addr_i  (wb_addr),
      .flag_set_i  (accept && cls.sets_flags),
      .flag_clr_i  (wb_flag_en),
      .rd1_addr_i  (r1),
      .rd2_addr_i  (r2),
      .rd1_pend_o  (r1_pend),
      .rd2_pend_o  (r2_pend),
      .flag_pend_o (flag_pend)
   );

   // Registered scoreboard only: a same-cycle writeback does not unblock
   assign hazard = (cls.reads_r1 && r1_pend) || (cls.reads_r2 && r2_pend) ||
                   (cls.writes_r1 && r1_pend) || (cls.reads_flags && flag_pend);
   assign in_ready = (state_q == ST_ISSUE) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      case (state_q)
         ST_ISSUE: begin
            if (accept) begin
               if (cls.is_mul && (MUL_CYCLES > 1)) begin
                  busy_d  = MUL_LOAD;
                  state_d = ST_MD_BUSY;
               end else if (cls.is_div && (DIV_CYCLES > 1)) begin
                  busy_d  = DIV_LOAD;
                  state_d = ST_MD_BUSY;
               end else if (cls.is_ctrl) begin
                  state_d = ST_BR_WAIT;
               end
            end
         end
         ST_MD_BUSY: begin
            busy_d = busy_q - BUSY_W'(1);
            if (busy_q == BUSY_W'(1)) state_d = ST_ISSUE;
         end
         ST_BR_WAIT: begin
            if (br_done) state_d = ST_ISSUE;
         end
         default: begin
            state_d = ST_ISSUE;
            busy_d  = '0;
         end
      endcase
   end

   always_comb begin
      out_instr_d = accept ? in_instr : NOP_INSTR;
      out_valid_d = accept;
      stall_d     = stall_q;
      if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_ISSUE;
         busy_q      <= '0;
         out_instr_q <= NOP_INSTR;
         out_valid_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         out_instr_q <= out_instr_d;
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
      end
   end

   assign out_instr = out_instr_q;
   assign out_valid = out_valid_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed vector table, async reset,
// randomized traffic against a behavioural model, and counter saturation.
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   localparam int MULC = 4;
   localparam int DIVC = 8;
   localparam int CW   = 16;

   logic                      clk_in = 1'b0;
   logic                      RST;
   logic [INSTR_WIDTH-1:0]    in_instr;
   logic                      in_valid, in_ready;
   logic                      wb_en, wb_flag_en, br_done;
   logic [REG_ADDR_WIDTH-1:0] wb_addr;
   logic [INSTR_WIDTH-1:0]    out_instr;
   logic                      out_valid;
   logic [CW-1:0]             stall_cnt;

   issue_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_WIDTH(CW)) dut (
      .clk_in     (clk_in),
      .RST        (RST),
      .in_instr   (in_instr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_flag_en (wb_flag_en),
      .br_done    (br_done),
      .out_instr  (out_instr),
      .out_valid  (out_valid),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: pending sets, next edge index at which issue is allowed
   bit                     m_pend [NUM_REGS];
   bit                     m_flag;
   bit                     m_brw;
   longint                 m_edge, m_next_ok;
   int                     m_stall;

   typedef struct {
      bit                     v;
      logic [INSTR_WIDTH-1:0] ins;
      bit                     we;
      int                     wa;
      bit                     wf;
      bit                     br;
      bit                     rdy;
      bit                     ov;
      int                     st;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [INSTR_WIDTH-1:0] mk(input opcode_e op, input int r1, input int r2);
      logic [INSTR_WIDTH-1:0] v;
      v = '0;
      v[OPCODE_WIDTH-1:0] = op;
      v[OPCODE_WIDTH +: REG_ADDR_WIDTH] = r1[REG_ADDR_WIDTH-1:0];
      v[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = r2[REG_ADDR_WIDTH-1:0];
      return v;
   endfunction

   function automatic opcode_e op_of(input logic [INSTR_WIDTH-1:0] ins);
      return opcode_e'(ins[OPCODE_WIDTH-1:0]);
   endfunction

   function automatic bit m_writer(input opcode_e op);
      return op inside {OP_LW, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT};
   endfunction

   function automatic bit m_ready(input logic [INSTR_WIDTH-1:0] ins);
      opcode_e op;
      int      r1, r2;
      bit      rd1, rd2;
      op  = op_of(ins);
      r1  = int'(ins[OPCODE_WIDTH +: REG_ADDR_WIDTH]);
      r2  = int'(ins[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH]);
      rd1 = op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_CMP, OP_SW, OP_JR};
      rd2 = op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_CMP, OP_SW, OP_LW, OP_NOT};
      if (m_brw || (m_edge < m_next_ok)) return 1'b0;
      if ((rd1 || m_writer(op)) && m_pend[r1]) return 1'b0;
      if (rd2 && m_pend[r2]) return 1'b0;
      if ((op == OP_BRFL) && m_flag) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void m_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_flag    = 1'b0;
      m_brw     = 1'b0;
      m_next_ok = m_edge;
      m_stall   = 0;
   endfunction

   // One clock: called at a negedge, returns at the next negedge
   task automatic cycle(input bit v, input logic [INSTR_WIDTH-1:0] ins, input bit we,
                        input int wa, input bit wf, input bit br, output bit rdy_seen);
      bit      rdy, acc;
      opcode_e op;
      in_valid   = v;
      in_instr   = ins;
      wb_en      = we;
      wb_addr    = wa[REG_ADDR_WIDTH-1:0];
      wb_flag_en = wf;
      br_done    = br;
      #1;
      rdy      = m_ready(ins);
      rdy_seen = in_ready;
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      @(posedge clk_in);
      acc = v && rdy;
      op  = op_of(ins);
      if (we) m_pend[wa] = 1'b0;
      if (wf) m_flag = 1'b0;
      if (acc) begin
         if (m_writer(op)) m_pend[int'(ins[OPCODE_WIDTH +: REG_ADDR_WIDTH])] = 1'b1;
         if (op == OP_CMP) m_flag = 1'b1;
         if (op == OP_MUL) m_next_ok = m_edge + MULC;
         if (op == OP_DIV) m_next_ok = m_edge + DIVC;
         if (op inside {OP_JR, OP_JPC, OP_BRFL, OP_CALL, OP_RET}) m_brw = 1'b1;
      end else if (m_brw && br) begin
         m_brw = 1'b0;
      end
      if (v && !rdy && (m_stall < 65535)) m_stall++;
      m_edge++;
      @(negedge clk_in);
      chk("out_valid", {63'd0, out_valid}, {63'd0, acc});
      chk("out_instr", 64'(out_instr), acc ? 64'(ins) : 64'd0);
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
   endtask

   task automatic add(input bit v, input logic [INSTR_WIDTH-1:0] ins, input bit we, input int wa,
                      input bit wf, input bit br, input bit rdy, input bit ov, input int st);
      vec_t e;
      e.v = v; e.ins = ins; e.we = we; e.wa = wa; e.wf = wf; e.br = br;
      e.rdy = rdy; e.ov = ov; e.st = st;
      tbl.push_back(e);
   endtask

   initial begin
      bit                     rs;
      logic [INSTR_WIDTH-1:0] ins;
      RST = 1'b0; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0; wb_addr = '0;
      wb_flag_en = 1'b0; br_done = 1'b0;
      m_edge = 0;
      m_reset();
      #2;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk_in);
      RST = 1'b1;

      // RAW
      add(1, mk(OP_ADD, 3, 17), 0, 0, 0, 0, 1, 1, 0);
      add(1, mk(OP_SUB, 5, 3),  0, 0, 0, 0, 0, 0, 1);
      add(1, mk(OP_SUB, 5, 3),  0, 0, 0, 0, 0, 0, 2);
      add(1, mk(OP_SUB, 5, 3),  1, 3, 0, 0, 0, 0, 3);
      add(1, mk(OP_SUB, 5, 3),  0, 0, 0, 0, 1, 1, 3);
      add(0, mk(OP_NOP, 0, 0),  1, 5, 0, 0, 1, 0, 3);
      // MUL occupancy
      add(1, mk(OP_MUL, 2, 3),  0, 0, 0, 0, 1, 1, 3);
      for (int i = 0; i < MULC-1; i++) add(1, mk(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0, 4+i);
      add(1, mk(OP_NOP, 0, 0),  1, 2, 0, 0, 1, 1, 6);
      // DIV occupancy
      add(1, mk(OP_DIV, 4, 3),  0, 0, 0, 0, 1, 1, 6);
      for (int i = 0; i < DIVC-1; i++) add(1, mk(OP_NOP, 0, 0), 0, 0, 0, 0, 0, 0, 7+i);
      add(1, mk(OP_NOP, 0, 0),  1, 4, 0, 0, 1, 1, 13);
      // flags and branch wait
      add(1, mk(OP_CMP, 0, 3),  0, 0, 0, 0, 1, 1, 13);
      add(1, mk(OP_BRFL, 0, 0), 0, 0, 0, 0, 0, 0, 14);
      add(1, mk(OP_BRFL, 0, 0), 0, 0, 1, 0, 0, 0, 15);
      add(1, mk(OP_BRFL, 0, 0), 0, 0, 0, 0, 1, 1, 15);
      add(1, mk(OP_NOP, 0, 0),  0, 0, 0, 0, 0, 0, 16);
      add(1, mk(OP_NOP, 0, 0),  0, 0, 0, 1, 0, 0, 17);
      add(1, mk(OP_NOP, 0, 0),  0, 0, 0, 0, 1, 1, 17);
      // set beats clear on the same register
      add(1, mk(OP_ADD, 2, 1),  1, 2, 0, 0, 1, 1, 17);
      add(1, mk(OP_SUB, 6, 2),  0, 0, 0, 0, 0, 0, 18);
      add(1, mk(OP_SUB, 6, 2),  1, 2, 0, 0, 0, 0, 19);
      add(1, mk(OP_SUB, 6, 2),  0, 0, 0, 0, 1, 1, 19);
      add(0, mk(OP_NOP, 0, 0),  1, 6, 0, 0, 1, 0, 19);
      add(1, mk(OP_JPC, 0, 0),  0, 0, 0, 0, 1, 1, 19);

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].ins, tbl[i].we, tbl[i].wa, tbl[i].wf, tbl[i].br, rs);
         chk($sformatf("vec%0d_ready", i), {63'd0, rs}, {63'd0, tbl[i].rdy});
         chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ov});
         chk($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].st));
      end

      // Async reset while waiting on a branch, no clock edge in between
      in_valid = 1'b1; in_instr = mk(OP_ADD, 1, 2); wb_en = 1'b0; br_done = 1'b0;
      #1;
      chk("brwait_in_ready", {63'd0, in_ready}, 64'd0);
      RST = 1'b0;
      #1;
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_out_instr", 64'(out_instr), 64'd0);
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      @(negedge clk_in);
      RST = 1'b1;
      m_reset();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         ins = mk(opcode_e'(OPCODE_WIDTH'($urandom_range(0, 15))),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         ins = ins | (INSTR_WIDTH'($urandom) << (OPCODE_WIDTH + 2*REG_ADDR_WIDTH));
         cycle(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), rs);
      end

      // Saturation under a permanent RAW hazard
      RST = 1'b0;
      #1;
      m_reset();
      @(negedge clk_in);
      RST = 1'b1;
      cycle(1'b1, mk(OP_ADD, 1, 1), 1'b0, 0, 1'b0, 1'b0, rs);
      in_valid = 1'b1; in_instr = mk(OP_SUB, 2, 1); wb_en = 1'b0;
      wb_flag_en = 1'b0; br_done = 1'b0;
      repeat (65534) @(posedge clk_in);
      @(negedge clk_in);
      chk("sat_pre", 64'(stall_cnt), 64'hFFFE);
      repeat (7) @(posedge clk_in);
      @(negedge clk_in);
      chk("sat_full", 64'(stall_cnt), 64'hFFFF);
      chk("sat_in_ready", {63'd0, in_ready}, 64'd0);
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk("sat_hold", 64'(stall_cnt), 64'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
